array_div_seq: RTL and testbench

Parametrised, handshaked, multicycle fixed-point divider array for the matrix-inverse datapath. It divides N signed dividends by one shared signed divisor and returns N quotients in the same fixed-point format, with truncation toward zero, saturation and a per-channel divide-by-zero flag. It sits between the pivot-selection stage and the row-normalisation stage and replaces the fixed six-lane, unhandshaked divider array. It adds valid/ready flow control, an `en` stall and a programmable fractional format.

---
 rtl/array_div_seq.sv | 141 ++++++++++++++
 tb/tb_array_div_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/array_div_seq.sv
// N-lane signed fixed-point divider sharing one divisor.
// Radix-2 restoring core, then saturation/zero fix-up in one cycle.
module array_div_seq #(
  parameter int N    = 6,
  parameter int W    = 27,
  parameter int FRAC = 13
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] dividends,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] quotients,
  output logic [N-1:0]   div_zero
);

  localparam int ITER = W + FRAC;
  localparam int NW   = W + FRAC;
  localparam int CW   = $clog2(ITER);

  localparam logic [W-1:0]  MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [NW-1:0] MAXQ = NW'(MAXV);
  localparam logic [NW-1:0] MINQ = NW'(MINV);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [N-1:0][W-1:0]     rem_q;
  logic [N-1:0][NW-1:0]    num_q;
  logic [N-1:0]            neg_q;
  logic [W-1:0]            dmag_q;
  logic [N*W-1:0]          quotients_q;
  logic [N-1:0]            div_zero_q;
  logic                    out_valid_q;

  logic [N-1:0][W-1:0]     mag_w;
  logic [W-1:0]            dmag_w;
  logic [N-1:0][NW-1:0]    ld_num_w;
  logic [N-1:0][W:0]       shl_w;
  logic [N-1:0][W-1:0]     sub_w;
  logic [N-1:0]            ge_w;
  logic [N-1:0][W-1:0]     rem_d;
  logic [N-1:0][NW-1:0]    num_d;
  logic [N-1:0][W-1:0]     fix_d;
  logic                    dzero_w;

  assign dmag_w = divisor[W-1] ? W'(0) - divisor : divisor;
  assign dzero_w = (dmag_q == '0);

  always_comb begin
    mag_w    = '0;
    ld_num_w = '0;
    shl_w    = '0;
    sub_w    = '0;
    ge_w     = '0;
    rem_d    = '0;
    num_d    = '0;
    fix_d    = '0;
    for (int i = 0; i < N; i++) begin
      mag_w[i] = dividends[i*W+W-1] ? W'(0) - dividends[i*W +: W]
                                    : dividends[i*W +: W];
      ld_num_w[i] = NW'(mag_w[i]) << FRAC;
      // remainder stays below the divisor, so W bits suffice
      shl_w[i] = {rem_q[i], num_q[i][NW-1]};
      ge_w[i]  = shl_w[i] >= {1'b0, dmag_q};
      sub_w[i] = shl_w[i][W-1:0] - dmag_q;
      rem_d[i] = ge_w[i] ? sub_w[i] : shl_w[i][W-1:0];
      num_d[i] = {num_q[i][NW-2:0], ge_w[i]};
      if (dzero_w)
        fix_d[i] = neg_q[i] ? MINV : MAXV;
      else if (!neg_q[i])
        fix_d[i] = (num_q[i] > MAXQ) ? MAXV : num_q[i][W-1:0];
      else
        fix_d[i] = (num_q[i] > MINQ) ? MINV
                                     : W'(0) - num_q[i][W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      num_q       <= '0;
      neg_q       <= '0;
      dmag_q      <= '0;
      quotients_q <= '0;
      div_zero_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            num_q  <= ld_num_w;
            rem_q  <= '0;
            dmag_q <= dmag_w;
            cnt_q  <= '0;
            for (int i = 0; i < N; i++)
              neg_q[i] <= dividends[i*W+W-1] ^ divisor[W-1];
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          num_q <= num_d;
          if (cnt_q == CW'(ITER - 1)) begin
            cnt_q   <= '0;
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIX: begin
          quotients_q <= fix_d;
          div_zero_q  <= {N{dzero_w}};
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign quotients = quotients_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_array_div_seq.sv
// Scoreboard bench for array_div_seq: directed cases plus random sets
// checked against an integer-arithmetic reference.
module tb_array_div_seq;

  localparam int N    = 6;
  localparam int W    = 27;
  localparam int FRAC = 13;
  localparam int ITER = W + FRAC;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] dividends;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] quotients;
  logic [N-1:0]   div_zero;

  typedef struct packed {
    logic [N*W-1:0] q;
    logic [N-1:0]   z;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   errs    = 0;

  array_div_seq #(.N(N), .W(W), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividends (dividends),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotients (quotients),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [N*W-1:0] dv,
                                 input logic [W-1:0] ds);
    exp_t   r;
    longint a, b, q;
    longint maxv, minv;
    maxv = (longint'(1) << (W - 1)) - 1;
    minv = -(longint'(1) << (W - 1));
    b = longint'($signed(ds));
    r = '0;
    for (int i = 0; i < N; i++) begin
      a = longint'($signed(dv[i*W +: W]));
      if (b == 0) begin
        q = (a >= 0) ? maxv : minv;
        r.z[i] = 1'b1;
      end else begin
        q = (a * (longint'(1) << FRAC)) / b;
        if (q > maxv) q = maxv;
        if (q < minv) q = minv;
      end
      r.q[i*W +: W] = q[W-1:0];
    end
    return r;
  endfunction

  function automatic logic [N*W-1:0] mk(input int a0, input int a1,
      input int a2, input int a3, input int a4, input int a5);
    int t[N];
    logic [N*W-1:0] r;
    t = '{a0, a1, a2, a3, a4, a5};
    for (int i = 0; i < N; i++) r[i*W +: W] = t[i][W-1:0];
    return r;
  endfunction

  function automatic logic [N*W-1:0] rnd_vec();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst && en && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL unexpected_output: got %h want none", quotients);
      end else begin
        mon_e = sb.pop_front();
        if (quotients !== mon_e.q || div_zero !== mon_e.z) begin
          errs++;
          $display("FAIL result: got q=%h z=%b want q=%h z=%b",
                   quotients, div_zero, mon_e.q, mon_e.z);
        end
      end
    end
  end

  task automatic check(input string nm, input logic ok,
                       input logic [N*W-1:0] got, input logic [N*W-1:0] want);
    vectors++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic run(input logic [N*W-1:0] dv, input logic [W-1:0] ds,
                     input int st_len, input bit hold, input int abort_at);
    int j;
    bit seen;
    logic [N*W-1:0] q0;
    j = 0;
    while (!in_ready && j < 200) begin
      @(posedge clk); #1; j++;
    end
    if (!in_ready) begin
      $display("FAIL in_ready_wait: got 0 want 1");
      $fatal(1);
    end
    if (abort_at == 0) sb.push_back(model(dv, ds));
    out_ready = !hold;
    in_valid  = 1'b1;
    dividends = dv;
    divisor   = ds;
    @(posedge clk); #1;
    in_valid = 1'b0;
    j = 0;
    seen = 1'b0;
    while (!seen && j < 200) begin
      @(posedge clk); #1; j++;
      if (j == abort_at) begin
        rst = 1'b0;
        #1;
        check("abort_reset", out_valid === 1'b0 && quotients === '0 &&
              div_zero === '0 && in_ready === 1'b1,
              {out_valid, in_ready, div_zero}, N*W'(1));
        #1 rst = 1'b1;
        return;
      end
      en = !(st_len > 0 && j >= 10 && j < 10 + st_len);
      in_valid = (j >= 5 && j < 15);
      if (in_valid) dividends = rnd_vec();
      if (j == 3)
        check("busy_in_ready", in_ready === 1'b0, N*W'(in_ready), '0);
      seen = out_valid;
    end
    in_valid = 1'b0;
    if (!seen) begin
      $display("FAIL timeout: got no out_valid want out_valid");
      $fatal(1);
    end
    check("latency", j == ITER + 1 + st_len, N*W'(j),
          N*W'(ITER + 1 + st_len));
    if (hold) begin
      q0 = quotients;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        check("hold_stable", quotients === q0 && out_valid === 1'b1 &&
              in_ready === 1'b0, quotients, q0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("post_handshake", out_valid === 1'b0 && in_ready === 1'b1,
            N*W'({out_valid, in_ready}), N*W'(1));
    end else begin
      @(posedge clk); #1;
    end
  endtask

  logic [N*W-1:0] v1;
  logic [W-1:0]   rd;

  initial begin
    rst = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    dividends = '0; divisor = '0;
    #12;
    check("reset", in_ready === 1'b1 && out_valid === 1'b0 &&
          quotients === '0 && div_zero === '0,
          N*W'({in_ready, out_valid}), N*W'(2));
    @(posedge clk); #1 rst = 1'b1;

    v1 = mk(24576, -24576, 0, 8192, -8192, 16384);
    run(v1, W'(16384), 0, 1'b0, 0);
    run(mk(8192, -8192, 1, -1, 24576, 0), W'(24576), 0, 1'b0, 0);
    run(mk(-8192, 8192, 1, -1, 0, 100), W'(-24576), 0, 1'b0, 0);
    run(mk(67108863, -67108864, 1, -1, 0, 8192), W'(1), 0, 1'b0, 0);
    run(mk(5, -5, 0, 67108863, -67108864, 1), W'(0), 0, 1'b0, 0);
    run(v1, W'(16384), 0, 1'b1, 0);
    run(v1, W'(16384), 7, 1'b0, 0);
    run(v1, W'(16384), 0, 1'b0, 20);
    run(v1, W'(16384), 0, 1'b0, 0);
    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 3))
        0:       rd = '0;
        1:       rd = W'($signed(9'($urandom)));
        default: rd = W'($urandom);
      endcase
      run(rnd_vec(), rd, 0, 1'b0, 0);
    end

    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    check("scoreboard_drained", sb.size() == 0, N*W'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
